// File: rtl/ovcam_seq_if.sv
// ROM fetch port and SCCB/I2C master handshake for the sensor config sequencer.
// master = sequencer side, slave = ROM + bus master side.
interface ovcam_seq_if #(
   parameter int ROM_AW = 9,
   parameter int REG_AW = 16
);
   logic              rom_rd;
   logic [ROM_AW-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic              bus_req;
   logic              bus_we;
   logic [REG_AW-1:0] bus_addr;
   logic [7:0]        bus_wdata;
   logic [7:0]        bus_rdata;
   logic              bus_ack;
   logic              bus_nack;

   modport master (
      output rom_rd, rom_addr, bus_req, bus_we, bus_addr, bus_wdata,
      input  rom_data, bus_rdata, bus_ack, bus_nack
   );
   modport slave (
      input  rom_rd, rom_addr, bus_req, bus_we, bus_addr, bus_wdata,
      output rom_data, bus_rdata, bus_ack, bus_nack
   );
endinterface

// File: rtl/ovcam_seq.sv
// Table-driven OmniVision sensor config sequencer: fetches command words from ROM
// and runs WRITE / DELAY / RMW / POLL / END through an SCCB req/ack master.
module ovcam_seq #(
   parameter int ROM_AW     = 9,
   parameter int REG_AW     = 16,
   parameter int DELAY_UNIT = 25000,
   parameter int POLL_GAP   = 25000,
   parameter int POLL_MAX   = 100,
   parameter int INIT_PAUSE = 500000,
   parameter int AUTO_START = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ROM_AW-1:0] table_base,
   ovcam_seq_if.master       bif,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);
   localparam int DW  = 24 + $clog2(DELAY_UNIT);
   localparam int GW  = $clog2(POLL_GAP + 1);
   localparam int IW  = $clog2(INIT_PAUSE + 1);
   localparam int CW0 = (DW > GW) ? DW : GW;
   localparam int CW  = (CW0 > IW) ? CW0 : IW;
   localparam int PW  = $clog2(POLL_MAX + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PAUSE, S_FETCH, S_DECODE, S_FETCH2, S_DECODE2,
      S_BUS, S_DELAY, S_GAP, S_DONE, S_ERR
   } state_t;
   typedef enum logic [1:0] {K_WR, K_RMW, K_POLL} kind_t;

   state_t            state_q, state_d;
   kind_t             kind_q, kind_d;
   logic [ROM_AW-1:0] addr_q, addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     poll_q, poll_d;
   logic              we_q, we_d;
   logic [REG_AW-1:0] idx_q, idx_d;
   logic [7:0]        wdata_q, wdata_d, mask_q, mask_d, val_q, val_d;
   logic              done_q, done_d, error_q, error_d, pend_q, pend_d;
   logic [1:0]        err_q, err_d;

   always_comb begin
      state_d = state_q;  kind_d  = kind_q;  addr_d  = addr_q;  cnt_d   = cnt_q;
      poll_d  = poll_q;   we_d    = we_q;    idx_d   = idx_q;   wdata_d = wdata_q;
      mask_d  = mask_q;   val_d   = val_q;   done_d  = done_q;  error_d = error_q;
      err_d   = err_q;    pend_d  = pend_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               done_d  = 1'b0;
               error_d = 1'b0;
               err_d   = 2'd0;
               pend_d  = 1'b0;
               addr_d  = table_base;
               state_d = S_FETCH;
            end else if (state_q == S_IDLE && pend_q) begin
               pend_d  = 1'b0;
               cnt_d   = CW'(INIT_PAUSE - 1);
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (cnt_q == '0) begin
               addr_d  = '0;
               state_d = S_FETCH;
            end else cnt_d = cnt_q - CW'(1);
         end
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            idx_d   = bif.rom_data[8 +: REG_AW];
            wdata_d = bif.rom_data[7:0];
            case (bif.rom_data[31:24])
               8'h00: begin kind_d = K_WR; we_d = 1'b1; state_d = S_BUS; end
               8'h01: begin
                  if (bif.rom_data[23:0] == 24'd0) begin
                     addr_d  = addr_q + ROM_AW'(1);
                     state_d = S_FETCH;
                  end else begin
                     cnt_d   = CW'(bif.rom_data[23:0]) * CW'(DELAY_UNIT) - CW'(1);
                     state_d = S_DELAY;
                  end
               end
               8'h02: begin kind_d = K_RMW; state_d = S_FETCH2; end
               8'h03: begin kind_d = K_POLL; poll_d = '0; state_d = S_FETCH2; end
               8'hFF: begin done_d = 1'b1; state_d = S_DONE; end
               default: begin error_d = 1'b1; err_d = 2'd3; state_d = S_ERR; end
            endcase
         end
         S_FETCH2:  state_d = S_DECODE2;
         S_DECODE2: begin
            mask_d  = bif.rom_data[15:8];
            val_d   = bif.rom_data[7:0];
            we_d    = 1'b0;
            state_d = S_BUS;
         end
         S_BUS: begin
            if (bif.bus_nack) begin
               error_d = 1'b1;
               err_d   = 2'd1;
               state_d = S_ERR;
            end else if (bif.bus_ack) begin
               case (kind_q)
                  K_RMW: begin
                     if (!we_q) begin
                        // one idle cycle between the read and the write keeps req edges distinct
                        wdata_d = (bif.bus_rdata & ~mask_q) | (val_q & mask_q);
                        we_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_GAP;
                     end else begin
                        addr_d  = addr_q + ROM_AW'(2);
                        state_d = S_FETCH;
                     end
                  end
                  K_POLL: begin
                     if (((bif.bus_rdata ^ val_q) & mask_q) == 8'h00) begin
                        addr_d  = addr_q + ROM_AW'(2);
                        state_d = S_FETCH;
                     end else if (poll_q == PW'(POLL_MAX - 1)) begin
                        error_d = 1'b1;
                        err_d   = 2'd2;
                        state_d = S_ERR;
                     end else begin
                        poll_d  = poll_q + PW'(1);
                        cnt_d   = CW'(POLL_GAP - 1);
                        state_d = S_GAP;
                     end
                  end
                  default: begin
                     addr_d  = addr_q + ROM_AW'(1);
                     state_d = S_FETCH;
                  end
               endcase
            end
         end
         S_DELAY: begin
            if (cnt_q == '0) begin
               addr_d  = addr_q + ROM_AW'(1);
               state_d = S_FETCH;
            end else cnt_d = cnt_q - CW'(1);
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_BUS;
            else cnt_d = cnt_q - CW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;  kind_q  <= K_WR;  addr_q  <= '0;  cnt_q   <= '0;
         poll_q  <= '0;      we_q    <= 1'b0;  idx_q   <= '0;  wdata_q <= '0;
         mask_q  <= '0;      val_q   <= '0;    done_q  <= 1'b0; error_q <= 1'b0;
         err_q   <= 2'd0;    pend_q  <= (AUTO_START != 0);
      end else begin
         state_q <= state_d; kind_q  <= kind_d; addr_q  <= addr_d; cnt_q   <= cnt_d;
         poll_q  <= poll_d;  we_q    <= we_d;   idx_q   <= idx_d;  wdata_q <= wdata_d;
         mask_q  <= mask_d;  val_q   <= val_d;  done_q  <= done_d; error_q <= error_d;
         err_q   <= err_d;   pend_q  <= pend_d;
      end
   end

   // addr_q always points at the command's first word so ERR reports it directly
   assign bif.rom_rd    = (state_q == S_FETCH) || (state_q == S_FETCH2);
   assign bif.rom_addr  = (state_q == S_FETCH2) ? addr_q + ROM_AW'(1) : addr_q;
   assign bif.bus_req   = (state_q == S_BUS);
   assign bif.bus_we    = we_q;
   assign bif.bus_addr  = idx_q;
   assign bif.bus_wdata = wdata_q;
   assign busy     = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
   assign done     = done_q;
   assign error    = error_q;
   assign err_code = err_q;
endmodule
